fp_mac_operand_loader: RTL and testbench
========================================

# fp_mac_operand_loader

Upstream front-end for the FP MAC core inside the `tt_um_*` top. It accepts a byte stream from the Tiny Tapeout pads and assembles it into a command plus two bfloat16 operands: a 5-byte frame of command, A_HI, A_LO, B_HI, B_LO. Byte timing at the pads is slow and asynchronous to `clk`, so the block synchronises the byte strobe. It presents one complete operation to the MAC datapath over a valid/ready handshake.

## Interface

Parameters:
- `OP_W`, 16: operand width in bits (bfloat16); must be 2 × `BYTE_W`.
- `BYTE_W`, 8: pad byte width.

Ports:
- `clk`  in  1  single system clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous and active-high; clears all state.
- `ena`  in  1  tile enable; low freezes the frame FSM.
- `in_byte`  in  `BYTE_W`  pad data (`ui_in`); quasi-static around strobe.
- `in_stb`  in  1  pad byte strobe (`uio_in[0]`), asynchronous level.
- `in_abort`  in  1  synchronous frame abort (already in `clk` domain).
- `op_a`  out  `OP_W`  operand A, {A_HI, A_LO}.
- `op_b`  out  `OP_W`  operand B, {B_HI, B_LO}.
- `op_clr`  out  1  command bit 0: clear accumulator before this MAC.
- `op_neg`  out  1  command bit 1: negate product.
- `op_valid`  out  1  operation held and stable.
- `op_ready`  in  1  MAC core accepts the operation.
- `busy`  out  1  frame partially received or awaiting handshake.
- `ovf`  out  1  sticky overrun flag.

## Operation

- The strobe passes through a 2-flop synchroniser and then a rising-edge detector, producing `byte_ev` as a 1-cycle pulse.
- The FSM has these states: CMD → A_HI → A_LO → B_HI → B_LO → ISSUE → CMD.
- In CMD through B_LO, each `byte_ev` with `ena` = 1 latches `in_byte` into the matching register and advances the state.
  - CMD latches `op_clr` = bit 0 and `op_neg` = bit 1. Bits 7:2 are ignored.
- On the `byte_ev` in B_LO, the state moves to ISSUE and `op_valid` is registered high on the same edge.
- In ISSUE, `op_a`, `op_b`, `op_clr` and `op_neg` hold stable.
  - On an edge with `op_valid` && `op_ready`, `op_valid` drops and the state returns to CMD.
- A `byte_ev` in ISSUE does not complete a handshake: the byte is dropped, `ovf` sets, and the state is unchanged.
- `byte_ev` pulses with `ena` = 0 are discarded. State, registers and `op_valid` hold. The synchroniser keeps running.
- `in_abort` = 1 on an edge forces the state to CMD and clears `op_valid` and `ovf`. Operand registers are kept.
  - Abort has priority over a simultaneous `byte_ev` and over a simultaneous handshake; in the handshake case the operation is not transferred.
- `busy` = 1 whenever the state is not CMD.

## Timing

- Reset values:
  - state CMD.
  - `op_a`, `op_b` = 0x0000.
  - `op_clr`, `op_neg`, `op_valid`, `busy`, `ovf` = 0.
  - Synchroniser flops = 0.
- Strobe latency: `in_stb` rising before clock edge k gives `byte_ev` high during cycle k+2. The byte is latched at edge k+3.
  - `in_byte` must be stable from strobe rise until 4 cycles after it.
  - The strobe must stay high ≥ 2 cycles and low ≥ 2 cycles between bytes.
- A strobe held high yields exactly one `byte_ev`.
- `op_valid` rises at the edge that latches B_LO. If `op_ready` is already high, the handshake completes at the next edge, so the minimum `op_valid` width is 1 cycle.
- The next frame's CMD byte may arrive in the cycle after the handshake edge.
- Reset asserted mid-frame clears state immediately, asynchronously. Partial frames are lost.

## Structure

- Package `fp_mac_pkg`:
  - state enum `ldr_state_t` (CMD, A_HI, A_LO, B_HI, B_LO, ISSUE).
  - `CMD_CLR_BIT` = 0 and `CMD_NEG_BIT` = 1.
  - `OP_W` default.
- One sub-module, `sync_edge_det`: 2-flop synchroniser plus rising-edge pulse, with the asynchronous active-high reset. It is reused for the other pad strobes in the top.
- The FSM, byte registers and handshake logic live in `fp_mac_operand_loader`.

## Test plan

- Basic frame:
  - Stimulus: send 0x01, 0x3F, 0xC0, 0x40, 0x00 with `op_ready` = 1.
  - Response: `op_a` = 0x3FC0, `op_b` = 0x4000, `op_clr` = 1, `op_neg` = 0, `op_valid` high exactly 1 cycle, then `busy` = 0.
- Backpressure:
  - Stimulus: frame 0x02, 0xBF, 0x80, 0x3F, 0x80 with `op_ready` = 0 for 10 cycles, then 1.
  - Response: `op_valid` held 10+ cycles with operands stable; `op_neg` = 1; handshake on the first edge with `op_ready` = 1.
  - Then stimulus: a 6th byte 0x55 during ISSUE.
  - Response: `ovf` = 1, operands unchanged, frame still issued.
- Abort:
  - Stimulus: send CMD, A_HI, A_LO, then pulse `in_abort` in the same cycle as the B_HI `byte_ev`.
  - Response: state CMD, `busy` = 0, `ovf` = 0. A following full frame decodes correctly with no stale-byte shift.
- Enable gating:
  - Stimulus: `ena` = 0 while 2 strobes arrive mid-frame.
  - Response: no state advance. After `ena` = 1, the remaining bytes complete the frame correctly.
- Strobe hygiene:
  - Stimulus: strobe held high 50 cycles.
  - Response: exactly one byte latched.
- Async reset:
  - Stimulus: reset asserted between clock edges during ISSUE.
  - Response: `op_valid` = 0 and `op_a` = 0x0000 before the next edge.

Source files
------------

// File: rtl/fp_mac_operand_loader_pkg.sv
// Shared types and constants for the FP MAC operand loader.
package fp_mac_pkg;

   localparam int OP_W_DEFAULT   = 16;
   localparam int BYTE_W_DEFAULT = 8;

   // Command byte bit positions.
   localparam int CMD_CLR_BIT = 0;
   localparam int CMD_NEG_BIT = 1;

   // Frame position: which byte the loader expects next, or ISSUE while
   // a completed operation waits for the MAC core.
   typedef enum logic [2:0] {
      CMD   = 3'd0,
      A_HI  = 3'd1,
      A_LO  = 3'd2,
      B_HI  = 3'd3,
      B_LO  = 3'd4,
      ISSUE = 3'd5
   } ldr_state_t;

endpackage

// File: rtl/fp_mac_operand_loader_if.sv
// Operation handshake between the operand loader and the MAC datapath.
interface fp_mac_operand_loader_if
   import fp_mac_pkg::*;
#(
   parameter int OP_W = OP_W_DEFAULT
);
   logic [OP_W-1:0] op_a;
   logic [OP_W-1:0] op_b;
   logic            op_clr;
   logic            op_neg;
   logic            op_valid;
   logic            op_ready;

   // Loader side: presents the operation.
   modport master (
      output op_a, op_b, op_clr, op_neg, op_valid,
      input  op_ready
   );

   // MAC side: consumes the operation.
   modport slave (
      input  op_a, op_b, op_clr, op_neg, op_valid,
      output op_ready
   );
endinterface

// File: rtl/fp_mac_operand_loader_sync_edge_det.sv
// Two-flop synchroniser for an asynchronous pad strobe followed by a
// registered rising-edge detector; a held-high strobe gives one pulse.
module sync_edge_det (
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic pulse
);
   logic meta;
   logic sync;
   logic sync_d;

   // Synchronise the level, delay it once more, and register the rise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta   <= 1'b0;
         sync   <= 1'b0;
         sync_d <= 1'b0;
         pulse  <= 1'b0;
      end else begin
         meta   <= async_in;
         sync   <= meta;
         sync_d <= sync;
         pulse  <= sync & ~sync_d;
      end
   end
endmodule

// File: rtl/fp_mac_operand_loader.sv
// Assembles a 5-byte pad frame (CMD, A_HI, A_LO, B_HI, B_LO) into one
// MAC operation and holds it on a valid/ready handshake.
//
// state | meaning
// ------+------------------------------------------------------------
// CMD   | idle / waiting for the command byte
// A_HI  | waiting for operand A high byte
// A_LO  | waiting for operand A low byte
// B_HI  | waiting for operand B high byte
// B_LO  | waiting for operand B low byte
// ISSUE | operation valid, waiting for op_ready; extra bytes flag ovf
module fp_mac_operand_loader
   import fp_mac_pkg::*;
#(
   parameter int OP_W   = OP_W_DEFAULT,
   parameter int BYTE_W = BYTE_W_DEFAULT
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     ena,
   input  logic [BYTE_W-1:0]        in_byte,
   input  logic                     in_stb,
   input  logic                     in_abort,
   fp_mac_operand_loader_if.master  op_if,
   output logic                     busy,
   output logic                     ovf
);
   ldr_state_t        state;
   ldr_state_t        state_nxt;
   logic              valid_q;
   logic              valid_nxt;
   logic              ovf_q;
   logic              ovf_nxt;
   logic              byte_ev;

   logic              ld_cmd;
   logic              ld_a_hi;
   logic              ld_a_lo;
   logic              ld_b_hi;
   logic              ld_b_lo;

   logic              clr_q;
   logic              neg_q;
   logic [BYTE_W-1:0] a_hi_q;
   logic [BYTE_W-1:0] a_lo_q;
   logic [BYTE_W-1:0] b_hi_q;
   logic [BYTE_W-1:0] b_lo_q;

   sync_edge_det u_stb_sync (
      .clk      (clk),
      .rst      (rst),
      .async_in (in_stb),
      .pulse    (byte_ev)
   );

   // FSM state, handshake valid and sticky overrun flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= CMD;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state   <= state_nxt;
         valid_q <= valid_nxt;
         ovf_q   <= ovf_nxt;
      end
   end

   // Next state and byte-load strobes; abort wins over bytes and handshake,
   // and a low ena freezes everything except abort.
   always_comb begin
      state_nxt = state;
      valid_nxt = valid_q;
      ovf_nxt   = ovf_q;
      ld_cmd    = 1'b0;
      ld_a_hi   = 1'b0;
      ld_a_lo   = 1'b0;
      ld_b_hi   = 1'b0;
      ld_b_lo   = 1'b0;
      if (in_abort) begin
         state_nxt = CMD;
         valid_nxt = 1'b0;
         ovf_nxt   = 1'b0;
      end else if (ena) begin
         case (state)
            CMD: begin
               if (byte_ev) begin
                  ld_cmd    = 1'b1;
                  state_nxt = A_HI;
               end
            end
            A_HI: begin
               if (byte_ev) begin
                  ld_a_hi   = 1'b1;
                  state_nxt = A_LO;
               end
            end
            A_LO: begin
               if (byte_ev) begin
                  ld_a_lo   = 1'b1;
                  state_nxt = B_HI;
               end
            end
            B_HI: begin
               if (byte_ev) begin
                  ld_b_hi   = 1'b1;
                  state_nxt = B_LO;
               end
            end
            B_LO: begin
               if (byte_ev) begin
                  ld_b_lo   = 1'b1;
                  state_nxt = ISSUE;
                  valid_nxt = 1'b1;
               end
            end
            ISSUE: begin
               if (byte_ev) begin
                  ovf_nxt = 1'b1;
               end
               if (valid_q && op_if.op_ready) begin
                  valid_nxt = 1'b0;
                  state_nxt = CMD;
               end
            end
            default: begin
               state_nxt = CMD;
               valid_nxt = 1'b0;
            end
         endcase
      end
   end

   // Command and operand byte registers; kept across abort, cleared by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clr_q  <= 1'b0;
         neg_q  <= 1'b0;
         a_hi_q <= '0;
         a_lo_q <= '0;
         b_hi_q <= '0;
         b_lo_q <= '0;
      end else begin
         if (ld_cmd) begin
            clr_q <= in_byte[CMD_CLR_BIT];
            neg_q <= in_byte[CMD_NEG_BIT];
         end
         if (ld_a_hi) a_hi_q <= in_byte;
         if (ld_a_lo) a_lo_q <= in_byte;
         if (ld_b_hi) b_hi_q <= in_byte;
         if (ld_b_lo) b_lo_q <= in_byte;
      end
   end

   assign op_if.op_a     = {a_hi_q, a_lo_q};
   assign op_if.op_b     = {b_hi_q, b_lo_q};
   assign op_if.op_clr   = clr_q;
   assign op_if.op_neg   = neg_q;
   assign op_if.op_valid = valid_q;
   assign busy           = (state != CMD);
   assign ovf            = ovf_q;

endmodule

// File: tb/tb_fp_mac_operand_loader.sv
// Directed bench for the FP MAC operand loader.
module tb_fp_mac_operand_loader;

   logic       clk = 1'b0;
   logic       rst;
   logic       ena;
   logic [7:0] in_byte;
   logic       in_stb;
   logic       in_abort;
   logic       busy;
   logic       ovf;

   int errors = 0;
   int checks = 0;

   int          valid_cycles = 0;
   int          xfers = 0;
   logic [15:0] cap_a = '0;
   logic [15:0] cap_b = '0;
   logic        cap_clr = 1'b0;
   logic        cap_neg = 1'b0;

   fp_mac_operand_loader_if #(.OP_W(16)) op_if ();

   fp_mac_operand_loader #(.OP_W(16), .BYTE_W(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .ena      (ena),
      .in_byte  (in_byte),
      .in_stb   (in_stb),
      .in_abort (in_abort),
      .op_if    (op_if),
      .busy     (busy),
      .ovf      (ovf)
   );

   always #5 clk = ~clk;

   // Handshake monitor: sees pre-edge values at each rising edge.
   always @(posedge clk) begin
      if (!rst && op_if.op_valid) valid_cycles++;
      if (!rst && ena && !in_abort && op_if.op_valid && op_if.op_ready) begin
         xfers++;
         cap_a   = op_if.op_a;
         cap_b   = op_if.op_b;
         cap_clr = op_if.op_clr;
         cap_neg = op_if.op_neg;
      end
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      in_byte = b;
      in_stb  = 1'b1;
      repeat (4) @(negedge clk);
      in_stb = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] c, input logic [7:0] ah, input logic [7:0] al,
                             input logic [7:0] bh, input logic [7:0] bl);
      send_byte(c);
      send_byte(ah);
      send_byte(al);
      send_byte(bh);
      send_byte(bl);
   endtask

   task automatic test_reset();
      rst = 1'b1; ena = 1'b1; in_byte = '0; in_stb = 1'b0; in_abort = 1'b0;
      op_if.op_ready = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (op_if.op_a !== 16'h0000) begin errors++; $display("FAIL reset_op_a: got %h want 0000", op_if.op_a); end
      checks++; if (op_if.op_b !== 16'h0000) begin errors++; $display("FAIL reset_op_b: got %h want 0000", op_if.op_b); end
      checks++; if ({op_if.op_clr, op_if.op_neg, op_if.op_valid} !== 3'b000) begin errors++; $display("FAIL reset_flags: clr/neg/valid got %b want 000", {op_if.op_clr, op_if.op_neg, op_if.op_valid}); end
      checks++; if ({busy, ovf} !== 2'b00) begin errors++; $display("FAIL reset_busy_ovf: got %b want 00", {busy, ovf}); end
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_strobe_latency();
      logic [3:0] seen;
      @(negedge clk);
      in_byte = 8'h00;
      in_stb  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         seen[i] = busy;
      end
      checks++; if (seen !== 4'b1000) begin errors++; $display("FAIL strobe_latency: busy after edges k..k+3 got %b want 1000 (lsb first edge)", seen); end
      in_stb = 1'b0;
      repeat (2) @(negedge clk);
      in_abort = 1'b1;
      @(negedge clk);
      in_abort = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL latency_abort_idle: busy got %b want 0", busy); end
   endtask

   task automatic test_basic_frame();
      int v0, x0;
      op_if.op_ready = 1'b1;
      v0 = valid_cycles; x0 = xfers;
      send_frame(8'h01, 8'h3F, 8'hC0, 8'h40, 8'h00);
      repeat (2) @(negedge clk);
      checks++; if (valid_cycles - v0 !== 1) begin errors++; $display("FAIL basic_valid_width: got %0d cycles want 1", valid_cycles - v0); end
      checks++; if (xfers - x0 !== 1) begin errors++; $display("FAIL basic_xfers: got %0d want 1", xfers - x0); end
      checks++; if (cap_a !== 16'h3FC0 || cap_b !== 16'h4000) begin errors++; $display("FAIL basic_operands: a=%h b=%h want 3fc0 4000", cap_a, cap_b); end
      checks++; if ({cap_clr, cap_neg} !== 2'b10) begin errors++; $display("FAIL basic_cmd: clr/neg got %b want 10", {cap_clr, cap_neg}); end
      checks++; if ({busy, op_if.op_valid} !== 2'b00) begin errors++; $display("FAIL basic_idle: busy/valid got %b want 00", {busy, op_if.op_valid}); end
   endtask

   task automatic test_backpressure();
      int v0, x0;
      op_if.op_ready = 1'b0;
      v0 = valid_cycles; x0 = xfers;
      send_frame(8'h02, 8'hBF, 8'h80, 8'h3F, 8'h80);
      checks++; if (op_if.op_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL bp_valid_held: valid/busy got %b%b want 11", op_if.op_valid, busy); end
      checks++; if (op_if.op_a !== 16'hBF80 || op_if.op_b !== 16'h3F80) begin errors++; $display("FAIL bp_operands: a=%h b=%h want bf80 3f80", op_if.op_a, op_if.op_b); end
      checks++; if ({op_if.op_clr, op_if.op_neg} !== 2'b01) begin errors++; $display("FAIL bp_cmd: clr/neg got %b want 01", {op_if.op_clr, op_if.op_neg}); end
      send_byte(8'h55);
      checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL bp_ovf_set: got %b want 1", ovf); end
      checks++; if (op_if.op_a !== 16'hBF80 || op_if.op_b !== 16'h3F80 || op_if.op_valid !== 1'b1) begin errors++; $display("FAIL bp_after_extra: a=%h b=%h valid=%b want bf80 3f80 1", op_if.op_a, op_if.op_b, op_if.op_valid); end
      for (int i = 0; i < 20 && (valid_cycles - v0) < 10; i++) @(negedge clk);
      checks++; if (valid_cycles - v0 < 10 || xfers - x0 !== 0) begin errors++; $display("FAIL bp_hold: valid cycles %0d xfers %0d want >=10 and 0", valid_cycles - v0, xfers - x0); end
      op_if.op_ready = 1'b1;
      @(negedge clk);
      checks++; if (op_if.op_valid !== 1'b0 || xfers - x0 !== 1) begin errors++; $display("FAIL bp_handshake: valid=%b xfers=%0d want 0 1", op_if.op_valid, xfers - x0); end
      checks++; if (cap_a !== 16'hBF80 || cap_b !== 16'h3F80) begin errors++; $display("FAIL bp_transferred: a=%h b=%h want bf80 3f80", cap_a, cap_b); end
      checks++; if (ovf !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL bp_sticky_ovf: ovf/busy got %b%b want 10", ovf, busy); end
   endtask

   task automatic test_abort();
      int x0;
      op_if.op_ready = 1'b1;
      send_byte(8'h00);
      send_byte(8'h11);
      send_byte(8'h22);
      @(negedge clk);
      in_byte = 8'h33;
      in_stb  = 1'b1;
      repeat (3) @(negedge clk);
      in_abort = 1'b1;
      @(negedge clk);
      in_abort = 1'b0;
      checks++; if ({busy, ovf, op_if.op_valid} !== 3'b000) begin errors++; $display("FAIL abort_state: busy/ovf/valid got %b want 000", {busy, ovf, op_if.op_valid}); end
      in_stb = 1'b0;
      repeat (2) @(negedge clk);
      x0 = xfers;
      send_frame(8'h03, 8'h12, 8'h34, 8'h56, 8'h78);
      repeat (2) @(negedge clk);
      checks++; if (xfers - x0 !== 1 || cap_a !== 16'h1234 || cap_b !== 16'h5678) begin errors++; $display("FAIL abort_next_frame: xfers=%0d a=%h b=%h want 1 1234 5678", xfers - x0, cap_a, cap_b); end
      checks++; if ({cap_clr, cap_neg} !== 2'b11) begin errors++; $display("FAIL abort_next_cmd: clr/neg got %b want 11", {cap_clr, cap_neg}); end
   endtask

   task automatic test_enable_gating();
      int x0;
      op_if.op_ready = 1'b1;
      x0 = xfers;
      send_byte(8'h00);
      send_byte(8'hAA);
      send_byte(8'hBB);
      ena = 1'b0;
      send_byte(8'hEE);
      send_byte(8'hDD);
      checks++; if (busy !== 1'b1 || op_if.op_valid !== 1'b0) begin errors++; $display("FAIL ena_frozen: busy/valid got %b%b want 10", busy, op_if.op_valid); end
      checks++; if (op_if.op_a !== 16'hAABB || op_if.op_b !== 16'h5678) begin errors++; $display("FAIL ena_regs_hold: a=%h b=%h want aabb 5678", op_if.op_a, op_if.op_b); end
      ena = 1'b1;
      send_byte(8'hCC);
      send_byte(8'hDD);
      repeat (2) @(negedge clk);
      checks++; if (xfers - x0 !== 1 || cap_a !== 16'hAABB || cap_b !== 16'hCCDD) begin errors++; $display("FAIL ena_resume: xfers=%0d a=%h b=%h want 1 aabb ccdd", xfers - x0, cap_a, cap_b); end
      checks++; if ({cap_clr, cap_neg, busy} !== 3'b000) begin errors++; $display("FAIL ena_cmd_idle: clr/neg/busy got %b want 000", {cap_clr, cap_neg, busy}); end
   endtask

   task automatic test_strobe_hygiene();
      int x0;
      op_if.op_ready = 1'b1;
      x0 = xfers;
      @(negedge clk);
      in_byte = 8'h01;
      in_stb  = 1'b1;
      repeat (50) @(negedge clk);
      in_stb = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (busy !== 1'b1 || op_if.op_valid !== 1'b0) begin errors++; $display("FAIL hold_one_byte: busy/valid got %b%b want 10", busy, op_if.op_valid); end
      send_byte(8'h11);
      send_byte(8'h22);
      send_byte(8'h33);
      send_byte(8'h44);
      repeat (2) @(negedge clk);
      checks++; if (xfers - x0 !== 1 || cap_a !== 16'h1122 || cap_b !== 16'h3344 || cap_clr !== 1'b1) begin errors++; $display("FAIL hold_frame: xfers=%0d a=%h b=%h clr=%b want 1 1122 3344 1", xfers - x0, cap_a, cap_b, cap_clr); end
   endtask

   task automatic test_async_reset();
      op_if.op_ready = 1'b0;
      send_frame(8'h05, 8'h01, 8'h02, 8'h03, 8'h04);
      checks++; if (op_if.op_valid !== 1'b1 || op_if.op_a !== 16'h0102) begin errors++; $display("FAIL arst_issue: valid=%b a=%h want 1 0102", op_if.op_valid, op_if.op_a); end
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      checks++; if (op_if.op_valid !== 1'b0 || op_if.op_a !== 16'h0000 || op_if.op_b !== 16'h0000) begin errors++; $display("FAIL arst_clear: valid=%b a=%h b=%h want 0 0000 0000", op_if.op_valid, op_if.op_a, op_if.op_b); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b want 0", busy); end
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_strobe_latency();
      test_basic_frame();
      test_backpressure();
      test_abort();
      test_enable_gating();
      test_strobe_hygiene();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
